// File: rtl/drop_scheduler.sv
// drop_scheduler: level-driven rate divider issuing drop ticks over a req/ack handshake.
// Build option DROP_OVERRUN_EN: counter keeps running in HOLD and overrun_cnt counts missed ticks.
`timescale 1ns/1ps
module drop_scheduler #(
   parameter logic [27:0] BASE_PERIOD     = 28'd29_999_998,
   parameter logic [27:0] LEVEL_STEP      = 28'd4_000_000,
   parameter logic [27:0] MIN_PERIOD      = 28'd4_000_000,
   parameter logic [27:0] SOFT_PERIOD     = 28'd4,
   parameter logic [6:0]  LINES_PER_LEVEL = 7'd10,
   parameter logic [2:0]  MAX_LEVEL       = 3'd7
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic       pause,
   input  logic       soft_drop,
   input  logic       game_over,
   input  logic       lines_valid,
   input  logic [2:0] lines_cleared,
   input  logic       drop_ack,
   output logic       drop_req,
   output logic [2:0] level,
   output logic [1:0] state,
   output logic [3:0] overrun_cnt
);

   // Handshake: drop_req rises on a tick and holds until drop_ack is seen high
   // while in HOLD; drop_ack in any other state is ignored.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      HOLD   = 2'b10,
      PAUSED = 2'b11
   } state_t;

   state_t      state_q, state_d;
   logic [27:0] cnt_q, cnt_d;
   logic        req_d;
   logic [2:0]  level_d;
   logic [6:0]  acc_q, acc_d;
   logic [27:0] lvl_period, eff_period;
   logic [2:0]  lines_sat;
   logic [6:0]  lines_sum;
`ifdef DROP_OVERRUN_EN
   logic [3:0]  ovr_q, ovr_d;
`endif

   // Saturating subtraction: never drops below MIN_PERIOD and never wraps.
   function automatic logic [27:0] period_for(input logic [2:0] lv);
      logic [31:0] red;
      red = 32'(lv) * 32'(LEVEL_STEP);
      if (red + 32'(MIN_PERIOD) <= 32'(BASE_PERIOD))
         return BASE_PERIOD - red[27:0];
      else
         return MIN_PERIOD;
   endfunction

   assign lvl_period = period_for(level);
   assign eff_period = soft_drop ? SOFT_PERIOD : lvl_period;
   assign lines_sat  = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
   assign lines_sum  = acc_q + {4'd0, lines_sat};
   assign state      = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = drop_req;
      level_d = level;
      acc_d   = acc_q;
`ifdef DROP_OVERRUN_EN
      ovr_d   = ovr_q;
`endif

      // Level changes only affect the next reload; lvl_period uses the old level here.
      if (state_q != IDLE && lines_valid) begin
         if (lines_sum >= LINES_PER_LEVEL) begin
            acc_d   = lines_sum - LINES_PER_LEVEL;
            level_d = (level >= MAX_LEVEL) ? MAX_LEVEL : level + 3'd1;
         end else begin
            acc_d = lines_sum;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               level_d = 3'd0;
               acc_d   = 7'd0;
               cnt_d   = period_for(3'd0);
`ifdef DROP_OVERRUN_EN
               ovr_d   = 4'd0;
`endif
            end
         end
         RUN: begin
            if (pause) begin
               state_d = PAUSED;
            end else if (cnt_q == 28'd0) begin
               state_d = HOLD;
               req_d   = 1'b1;
               cnt_d   = eff_period;
            end else if (soft_drop && cnt_q > SOFT_PERIOD) begin
               cnt_d = SOFT_PERIOD;
            end else begin
               cnt_d = cnt_q - 28'd1;
            end
         end
         HOLD: begin
            if (drop_ack) begin
               req_d   = 1'b0;
               state_d = pause ? PAUSED : RUN;
            end
`ifdef DROP_OVERRUN_EN
            if (cnt_q == 28'd0) begin
               cnt_d = eff_period;
               ovr_d = (ovr_q == 4'd15) ? 4'd15 : ovr_q + 4'd1;
            end else begin
               cnt_d = cnt_q - 28'd1;
            end
`endif
         end
         default: begin
            if (!pause) state_d = RUN;
         end
      endcase

      if (game_over) begin
         state_d = IDLE;
         req_d   = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= 28'd0;
         drop_req <= 1'b0;
         level    <= 3'd0;
         acc_q    <= 7'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         drop_req <= req_d;
         level    <= level_d;
         acc_q    <= acc_d;
      end
   end

`ifdef DROP_OVERRUN_EN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) ovr_q <= 4'd0;
      else         ovr_q <= ovr_d;
   end
   assign overrun_cnt = ovr_q;
`else
   assign overrun_cnt = 4'd0;
`endif

endmodule
